// File: rtl/psychic5_video_capture.sv
// rtl/psychic5_video_capture.sv - Psychic5 active-window capture into a FWFT pixel stream with SOF/EOL/EOF markers
module psychic5_video_capture #(
  parameter logic [8:0] H_ACT_START  = 9'd128,
  parameter int         H_ACT_WIDTH  = 256,
  parameter logic [8:0] V_ACT_START  = 9'd16,
  parameter int         V_ACT_HEIGHT = 224,
  parameter int         FIFO_DEPTH   = 16
) (
  input  logic        i_EMU_MCLK,
  input  logic        i_EMU_RST,
  input  logic        i_EMU_CLK6MPCEN_n,
  input  logic [8:0]  i_HCOUNTER,
  input  logic [8:0]  i_VCOUNTER,
  input  logic [11:0] i_VIDEODATA,
  input  logic        i_ENABLE,
  output logic [11:0] o_PX_DATA,
  output logic        o_PX_SOF,
  output logic        o_PX_EOL,
  output logic        o_PX_EOF,
  output logic        o_PX_VALID,
  input  logic        i_PX_READY,
  output logic        o_OVERFLOW,
  output logic [7:0]  o_FRAME_CNT,
  output logic        o_BUSY
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  // Window bounds widened to 10 bits so start+width never wraps
  localparam logic [9:0] H_LO = {1'b0, H_ACT_START};
  localparam logic [9:0] H_HI = H_LO + 10'(H_ACT_WIDTH);
  localparam logic [9:0] V_LO = {1'b0, V_ACT_START};
  localparam logic [9:0] V_HI = V_LO + 10'(V_ACT_HEIGHT);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_CAPTURE, ST_DROP} state_t;
  state_t state;

  logic        strobe;
  logic [9:0]  h10, v10;
  logic        in_win, at_sof, at_eol, at_eof;
  logic [14:0] push_word;

  logic        push_req, push_ok, push_lost, pop, full;
  logic [14:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_next;
  logic [AW:0]   count, count_after_pop, count_next;
  logic [14:0] out_word, out_next;

  assign strobe    = ~i_EMU_CLK6MPCEN_n;
  assign h10       = {1'b0, i_HCOUNTER};
  assign v10       = {1'b0, i_VCOUNTER};
  assign in_win    = (h10 >= H_LO) && (h10 < H_HI) && (v10 >= V_LO) && (v10 < V_HI);
  assign at_sof    = (h10 == H_LO) && (v10 == V_LO);
  assign at_eol    = (h10 == H_HI - 10'd1);
  assign at_eof    = at_eol && (v10 == V_HI - 10'd1);
  assign push_word = {at_eof, at_eol, at_sof, i_VIDEODATA};

  assign o_PX_DATA = out_word[11:0];
  assign o_PX_SOF  = out_word[12];
  assign o_PX_EOL  = out_word[13];
  assign o_PX_EOF  = out_word[14];

  // Push request per state, FIFO occupancy arithmetic and next head word
  always_comb begin
    push_req = 1'b0;
    case (state)
      ST_ARMED, ST_DROP: push_req = strobe && i_ENABLE && at_sof;
      ST_CAPTURE:        push_req = strobe && in_win;
      default:           push_req = 1'b0;
    endcase
    pop             = o_PX_VALID && i_PX_READY;
    full            = (count == FULL_CNT);
    push_ok         = push_req && (!full || pop);
    push_lost       = push_req && full && !pop;
    count_after_pop = count - (AW+1)'(pop);
    count_next      = count_after_pop + (AW+1)'(push_ok);
    rd_ptr_next     = rd_ptr + AW'(pop);
    // An empty FIFO takes the head straight from the word being written
    out_next = 15'd0;
    if (count_after_pop != '0)
      out_next = mem[rd_ptr_next];
    else if (push_ok)
      out_next = push_word;
  end

  // FIFO storage, written only on accepted pushes
  always_ff @(posedge i_EMU_MCLK) begin
    if (push_ok)
      mem[wr_ptr] <= push_word;
  end

  // FIFO pointers, count and registered head word / valid
  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      out_word   <= '0;
      o_PX_VALID <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= rd_ptr_next;
      count      <= count_next;
      out_word   <= out_next;
      o_PX_VALID <= (count_next != '0);
    end
  end

  // Capture state machine with frame counter, sticky overflow and busy flag
  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_RST) begin
      state       <= ST_IDLE;
      o_BUSY      <= 1'b0;
      o_OVERFLOW  <= 1'b0;
      o_FRAME_CNT <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_ENABLE)
            state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (!i_ENABLE) begin
            state <= ST_IDLE;
          end else if (push_ok) begin
            state  <= ST_CAPTURE;
            o_BUSY <= 1'b1;
          end else if (push_lost) begin
            state      <= ST_DROP;
            o_OVERFLOW <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (push_lost) begin
            state      <= ST_DROP;
            o_BUSY     <= 1'b0;
            o_OVERFLOW <= 1'b1;
          end else if (push_ok && at_eof) begin
            o_FRAME_CNT <= o_FRAME_CNT + 8'd1;
            o_BUSY      <= 1'b0;
            state       <= i_ENABLE ? ST_ARMED : ST_IDLE;
          end
        end
        ST_DROP: begin
          // Discard everything until a SOF sample realigns us to a frame
          if (strobe && at_sof && !i_ENABLE) begin
            state <= ST_IDLE;
          end else if (push_ok) begin
            state  <= ST_CAPTURE;
            o_BUSY <= 1'b1;
          end else if (push_lost) begin
            o_OVERFLOW <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          o_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psychic5_video_capture.sv
// tb/tb_psychic5_video_capture.sv - directed bench for psychic5_video_capture on a reduced 16x8 raster
module tb_psychic5_video_capture;

  logic        i_EMU_MCLK = 1'b0;
  logic        i_EMU_RST = 1'b1;
  logic        i_EMU_CLK6MPCEN_n = 1'b1;
  logic [8:0]  i_HCOUNTER = 9'd0;
  logic [8:0]  i_VCOUNTER = 9'd0;
  logic [11:0] i_VIDEODATA = 12'd0;
  logic        i_ENABLE = 1'b0;
  logic        i_PX_READY = 1'b0;
  logic [11:0] o_PX_DATA;
  logic        o_PX_SOF, o_PX_EOL, o_PX_EOF, o_PX_VALID;
  logic        o_OVERFLOW;
  logic [7:0]  o_FRAME_CNT;
  logic        o_BUSY;

  int checks = 0;
  int failures = 0;
  int gh = 0;
  int gv = 0;
  logic [14:0] beats[$];

  // Raster: h 0..15, v 0..7; active h 4..11, v 2..5 -> 32 pixels per frame
  psychic5_video_capture #(
    .H_ACT_START(9'd4), .H_ACT_WIDTH(8), .V_ACT_START(9'd2), .V_ACT_HEIGHT(4), .FIFO_DEPTH(8)
  ) dut (
    .i_EMU_MCLK(i_EMU_MCLK), .i_EMU_RST(i_EMU_RST), .i_EMU_CLK6MPCEN_n(i_EMU_CLK6MPCEN_n),
    .i_HCOUNTER(i_HCOUNTER), .i_VCOUNTER(i_VCOUNTER), .i_VIDEODATA(i_VIDEODATA),
    .i_ENABLE(i_ENABLE), .o_PX_DATA(o_PX_DATA), .o_PX_SOF(o_PX_SOF), .o_PX_EOL(o_PX_EOL),
    .o_PX_EOF(o_PX_EOF), .o_PX_VALID(o_PX_VALID), .i_PX_READY(i_PX_READY),
    .o_OVERFLOW(o_OVERFLOW), .o_FRAME_CNT(o_FRAME_CNT), .o_BUSY(o_BUSY)
  );

  always #5 i_EMU_MCLK = ~i_EMU_MCLK;

  function automatic logic [14:0] expected_word(input int i);
    logic [8:0] hh, vv;
    hh = 9'(4 + i % 8);
    vv = 9'(2 + i / 8);
    return {(i == 31), ((i % 8) == 7), (i == 0), vv[3:0], hh[7:0]};
  endfunction

  task automatic drive_gen();
    logic [8:0] hh, vv;
    hh = 9'(gh);
    vv = 9'(gv);
    i_HCOUNTER  = hh;
    i_VCOUNTER  = vv;
    i_VIDEODATA = {vv[3:0], hh[7:0]};
  endtask

  task automatic step();
    if (o_PX_VALID && i_PX_READY)
      beats.push_back({o_PX_EOF, o_PX_EOL, o_PX_SOF, o_PX_DATA});
    @(posedge i_EMU_MCLK);
    #1;
    if (!i_EMU_CLK6MPCEN_n) begin
      gh++;
      if (gh == 16) begin
        gh = 0;
        gv++;
        if (gv == 8) gv = 0;
      end
    end
    i_EMU_CLK6MPCEN_n = ~i_EMU_CLK6MPCEN_n;
    drive_gen();
  endtask

  task automatic run_until(input int h, input int v, input string name);
    int n;
    n = 0;
    while (!(gv == v && (h < 0 || gh == h)) && n < 4000) begin
      step();
      n++;
    end
    checks++;
    if (!(gv == v && (h < 0 || gh == h))) begin
      failures++;
      $display("FAIL %s_wait timeout: at h=%0d v=%0d, wanted h=%0d v=%0d", name, gh, gv, h, v);
    end
  endtask

  task automatic do_reset();
    i_EMU_RST = 1'b1;
    repeat (3) step();
    i_EMU_RST = 1'b0;
    gh = 0;
    gv = 0;
    i_EMU_CLK6MPCEN_n = 1'b1;
    drive_gen();
    beats.delete();
  endtask

  task automatic test_reset();
    i_ENABLE = 1'b0;
    i_PX_READY = 1'b0;
    i_EMU_RST = 1'b1;
    repeat (4) step();
    checks++;
    if (o_PX_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", o_PX_VALID); end
    checks++;
    if ({o_PX_EOF, o_PX_EOL, o_PX_SOF, o_PX_DATA} !== 15'd0) begin
      failures++; $display("FAIL reset_data got=%h want=0", {o_PX_EOF, o_PX_EOL, o_PX_SOF, o_PX_DATA});
    end
    checks++;
    if (o_OVERFLOW !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b want=0", o_OVERFLOW); end
    checks++;
    if (o_FRAME_CNT !== 8'd0) begin failures++; $display("FAIL reset_frame_cnt got=%0d want=0", o_FRAME_CNT); end
    checks++;
    if (o_BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", o_BUSY); end
    i_EMU_RST = 1'b0;
  endtask

  task automatic test_full_frame();
    int bad;
    do_reset();
    i_ENABLE = 1'b1;
    i_PX_READY = 1'b1;
    run_until(-1, 7, "full_frame");
    bad = 0;
    for (int i = 0; i < beats.size() && i < 32; i++)
      if (beats[i] !== expected_word(i)) bad++;
    checks++;
    if (beats.size() != 32 || bad != 0) begin
      failures++; $display("FAIL full_frame_beats got=%0d beats (%0d wrong) want=32 (0 wrong)", beats.size(), bad);
    end
    checks++;
    if (o_FRAME_CNT !== 8'd1) begin failures++; $display("FAIL full_frame_cnt got=%0d want=1", o_FRAME_CNT); end
    checks++;
    if (o_BUSY !== 1'b0 || o_OVERFLOW !== 1'b0) begin
      failures++; $display("FAIL full_frame_flags got busy=%b ovf=%b want 0 0", o_BUSY, o_OVERFLOW);
    end
    run_until(-1, 3, "full_frame_rearm");
    checks++;
    if (o_BUSY !== 1'b1) begin failures++; $display("FAIL full_frame_rearm_busy got=%b want=1", o_BUSY); end
  endtask

  task automatic test_late_enable();
    int bad;
    do_reset();
    i_ENABLE = 1'b0;
    i_PX_READY = 1'b1;
    run_until(-1, 3, "late_enable");
    i_ENABLE = 1'b1;
    run_until(-1, 7, "late_enable");
    checks++;
    if (beats.size() != 0) begin failures++; $display("FAIL late_enable_partial got=%0d beats want=0", beats.size()); end
    run_until(-1, 0, "late_enable");
    run_until(-1, 7, "late_enable");
    bad = 0;
    for (int i = 0; i < beats.size() && i < 32; i++)
      if (beats[i] !== expected_word(i)) bad++;
    checks++;
    if (beats.size() != 32 || bad != 0) begin
      failures++; $display("FAIL late_enable_beats got=%0d beats (%0d wrong) want=32 (0 wrong)", beats.size(), bad);
    end
    checks++;
    if (o_FRAME_CNT !== 8'd1) begin failures++; $display("FAIL late_enable_cnt got=%0d want=1", o_FRAME_CNT); end
  endtask

  task automatic test_overflow();
    int bad, eofs, base;
    do_reset();
    i_ENABLE = 1'b1;
    i_PX_READY = 1'b1;
    run_until(4, 3, "overflow");
    i_PX_READY = 1'b0;
    repeat (40) step();
    i_PX_READY = 1'b1;
    checks++;
    if (o_OVERFLOW !== 1'b1) begin failures++; $display("FAIL overflow_flag got=%b want=1", o_OVERFLOW); end
    run_until(-1, 7, "overflow");
    run_until(-1, 0, "overflow");
    run_until(-1, 7, "overflow");
    eofs = 0;
    foreach (beats[i]) if (beats[i][14]) eofs++;
    checks++;
    if (eofs != 1 || beats.size() <= 32) begin
      failures++; $display("FAIL overflow_eofs got eof=%0d beats=%0d want eof=1 beats>32", eofs, beats.size());
    end
    bad = 0;
    base = beats.size() - 32;
    for (int i = 0; i < 32 && base >= 0; i++)
      if (beats[base + i] !== expected_word(i)) bad++;
    checks++;
    if (base < 0 || bad != 0) begin failures++; $display("FAIL overflow_next_frame got %0d wrong want 0", bad); end
    checks++;
    if (o_FRAME_CNT !== 8'd1) begin failures++; $display("FAIL overflow_cnt got=%0d want=1", o_FRAME_CNT); end
    checks++;
    if (o_OVERFLOW !== 1'b1) begin failures++; $display("FAIL overflow_sticky got=%b want=1", o_OVERFLOW); end
  endtask

  task automatic test_toggle_ready();
    int bad, unstable;
    logic pv, pr;
    logic [14:0] pw;
    do_reset();
    i_ENABLE = 1'b1;
    i_PX_READY = 1'b1;
    unstable = 0;
    for (int n = 0; n < 240; n++) begin
      i_PX_READY = ~i_PX_READY;
      pv = o_PX_VALID;
      pr = i_PX_READY;
      pw = {o_PX_EOF, o_PX_EOL, o_PX_SOF, o_PX_DATA};
      step();
      if (pv && !pr && (o_PX_VALID !== 1'b1 || {o_PX_EOF, o_PX_EOL, o_PX_SOF, o_PX_DATA} !== pw))
        unstable++;
    end
    checks++;
    if (unstable != 0) begin failures++; $display("FAIL toggle_stable got=%0d changes want=0", unstable); end
    bad = 0;
    for (int i = 0; i < beats.size() && i < 32; i++)
      if (beats[i] !== expected_word(i)) bad++;
    checks++;
    if (beats.size() != 32 || bad != 0) begin
      failures++; $display("FAIL toggle_beats got=%0d beats (%0d wrong) want=32 (0 wrong)", beats.size(), bad);
    end
    checks++;
    if (o_OVERFLOW !== 1'b0) begin failures++; $display("FAIL toggle_overflow got=%b want=0", o_OVERFLOW); end
  endtask

  task automatic test_enable_drop();
    int bad;
    do_reset();
    i_ENABLE = 1'b1;
    i_PX_READY = 1'b1;
    run_until(-1, 3, "enable_drop");
    i_ENABLE = 1'b0;
    run_until(-1, 7, "enable_drop");
    bad = 0;
    for (int i = 0; i < beats.size() && i < 32; i++)
      if (beats[i] !== expected_word(i)) bad++;
    checks++;
    if (beats.size() != 32 || bad != 0) begin
      failures++; $display("FAIL enable_drop_beats got=%0d beats (%0d wrong) want=32 (0 wrong)", beats.size(), bad);
    end
    checks++;
    if (o_BUSY !== 1'b0 || o_FRAME_CNT !== 8'd1) begin
      failures++; $display("FAIL enable_drop_state got busy=%b cnt=%0d want busy=0 cnt=1", o_BUSY, o_FRAME_CNT);
    end
    run_until(-1, 0, "enable_drop");
    run_until(-1, 7, "enable_drop");
    checks++;
    if (beats.size() != 32 || o_PX_VALID !== 1'b0) begin
      failures++; $display("FAIL enable_drop_idle got beats=%0d valid=%b want 32 0", beats.size(), o_PX_VALID);
    end
  endtask

  task automatic test_reset_midframe();
    int bad;
    do_reset();
    i_ENABLE = 1'b1;
    i_PX_READY = 1'b1;
    run_until(-1, 7, "reset_mid");
    run_until(-1, 0, "reset_mid");
    run_until(4, 3, "reset_mid");
    i_PX_READY = 1'b0;
    repeat (10) step();
    checks++;
    if (o_PX_VALID !== 1'b1 || o_FRAME_CNT !== 8'd1) begin
      failures++; $display("FAIL reset_mid_pre got valid=%b cnt=%0d want 1 1", o_PX_VALID, o_FRAME_CNT);
    end
    i_EMU_RST = 1'b1;
    step();
    i_EMU_RST = 1'b0;
    checks++;
    if (o_PX_VALID !== 1'b0 || o_FRAME_CNT !== 8'd0 || o_OVERFLOW !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_post got valid=%b cnt=%0d ovf=%b want 0 0 0", o_PX_VALID, o_FRAME_CNT, o_OVERFLOW);
    end
    beats.delete();
    i_PX_READY = 1'b1;
    run_until(-1, 7, "reset_mid");
    checks++;
    if (beats.size() != 0) begin failures++; $display("FAIL reset_mid_flushed got=%0d beats want=0", beats.size()); end
    run_until(-1, 0, "reset_mid");
    run_until(-1, 7, "reset_mid");
    bad = 0;
    for (int i = 0; i < beats.size() && i < 32; i++)
      if (beats[i] !== expected_word(i)) bad++;
    checks++;
    if (beats.size() != 32 || bad != 0 || o_FRAME_CNT !== 8'd1) begin
      failures++;
      $display("FAIL reset_mid_resume got=%0d beats (%0d wrong) cnt=%0d want=32 (0 wrong) cnt=1", beats.size(), bad, o_FRAME_CNT);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_late_enable();
    test_overflow();
    test_toggle_ready();
    test_enable_drop();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
